// File: rtl/win_acc_pkg.sv
// Shared types and default constants for the window accumulator slice.
// The state encoding is fixed so the state register can be probed directly.
package win_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int WIN_LEN_DEF = 8;
  localparam int SUM_W_DEF   = 5;
  localparam int THRESH_DEF  = 12;

  // Bits needed to count 0..win_len inclusive.
  function automatic int cnt_width(input int win_len);
    return $clog2(win_len + 1);
  endfunction

endpackage

// File: rtl/win_counter.sv
// Sample counter for one window: counts accepted samples up to WIN_LEN and
// flags the enable cycle that brings the count to WIN_LEN.
module win_counter
  import win_acc_pkg::*;
#(
  parameter  int WIN_LEN = WIN_LEN_DEF,
  localparam int CNT_W   = cnt_width(WIN_LEN)
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CNT_W-1:0] count_q;

  // tc is qualified by enable so the FSM can leave ACC on the very edge
  // that accepts the final sample.
  assign tc = enable && (count_q == CNT_W'(WIN_LEN - 1));

  // NOTE: sequential state is only ever written with non-blocking assignments
  // so every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != CNT_W'(WIN_LEN))) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/win_accumulator.sv
// Sums WIN_LEN valid 2-bit samples per window and hands the total, threshold
// flag and sticky overflow downstream over valid/ready.
// Build option: define WIN_ACC_SAT_EN to saturate the sum instead of wrapping.
module win_accumulator
  import win_acc_pkg::*;
#(
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int SUM_W   = SUM_W_DEF,
  parameter int THRESH  = THRESH_DEF
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [1:0]       in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_over,
  output logic             overflow,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [SUM_W-1:0] sum_q;
  logic             ovf_q;
  logic             busy_q;
  logic             out_valid_q;

  logic             clr;
  logic             acc_en;
  logic             last;
  logic [SUM_W:0]   sum_ext;
  logic             carry;
  logic [SUM_W-1:0] sum_next;

  win_counter #(.WIN_LEN(WIN_LEN)) u_counter (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .clear  (clr),
    .enable (acc_en),
    .tc     (last)
  );

  // One extra bit captures the carry out of the SUM_W-bit sum.
  assign sum_ext = {1'b0, sum_q} + (SUM_W + 1)'(in_data);
  assign carry   = sum_ext[SUM_W];

`ifdef WIN_ACC_SAT_EN
  assign sum_next = carry ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
`else
  assign sum_next = sum_ext[SUM_W-1:0];
`endif

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          clr     = 1'b1;
        end
      end
      ACC: begin
        if (start) begin
          clr = 1'b1;
        end else if (in_valid) begin
          acc_en = 1'b1;
          if (last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (start) begin
            state_d = ACC;
            clr     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d == ACC);
      out_valid_q <= (state_d == DONE);
      if (clr) begin
        sum_q <= '0;
        ovf_q <= 1'b0;
      end else if (acc_en) begin
        sum_q <= sum_next;
        if (carry) ovf_q <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;
  assign out_over  = out_valid_q && (int'(sum_q) >= THRESH);

endmodule

// File: tb/tb_win_accumulator.sv
// Directed bench for win_accumulator: default instance plus a SUM_W=4
// instance sharing the same stimulus for the wrap/saturate case.
module tb_win_accumulator;
  import win_acc_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       start, in_valid, out_ready;
  logic [1:0] in_data;

  logic       out_valid, out_over, overflow, busy;
  logic [4:0] out_sum;
  logic       out_valid4, out_over4, overflow4, busy4;
  logic [3:0] out_sum4;

  int n_checks = 0;
  int n_errors = 0;

  localparam int SUM_IDX [8] = '{1, 0, 2, 1, 0, 1, 1, 0};

`ifdef WIN_ACC_SAT_EN
  localparam int EXP4_24 = 15;
  localparam int EXP4_16 = 15;
  localparam int EXP4_OVER24 = 1;
`else
  localparam int EXP4_24 = 8;
  localparam int EXP4_16 = 0;
  localparam int EXP4_OVER24 = 0;
`endif

  always #5 Clk = ~Clk;

  win_accumulator dut (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .out_ready(out_ready), .out_valid(out_valid),
    .out_sum(out_sum), .out_over(out_over), .overflow(overflow), .busy(busy)
  );

  win_accumulator #(.SUM_W(4)) dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .out_ready(out_ready), .out_valid(out_valid4),
    .out_sum(out_sum4), .out_over(out_over4), .overflow(overflow4), .busy(busy4)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs set afterwards apply at the next edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic feed(input logic [1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = 2'd0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_sum"},   int'(out_sum),   0);
    check({tag, "_over"},  int'(out_over),  0);
    check({tag, "_ovf"},   int'(overflow),  0);
    check({tag, "_busy"},  int'(busy),      0);
    check({tag, "_state"}, int'(dut.state_q), int'(IDLE));
  endtask

  initial begin
    Rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 2'd0; out_ready = 1'b0;
    #3;
    check_cleared("reset");
    check("reset_count", int'(dut.u_counter.count_q), 0);
    #9 Rst_n = 1'b1;
    step();

    // Window of 8 x 3, ready held high.
    out_ready = 1'b1;
    start = 1'b1; in_valid = 1'b1; in_data = 2'd3;  // sample on start cycle dropped
    step();
    start = 1'b0;
    check("t1_busy", int'(busy), 1);
    check("t1_sum0", int'(out_sum), 0);
    for (int i = 0; i < 7; i++) feed(2'd3);
    check("t1_valid_early", int'(out_valid), 0);
    feed(2'd3);
    check("t1_valid", int'(out_valid), 1);
    check("t1_sum",   int'(out_sum), 24);
    check("t1_over",  int'(out_over), 1);
    check("t1_ovf",   int'(overflow), 0);
    check("t1_busy_done", int'(busy), 0);
    check("t1_sum4",  int'(out_sum4), EXP4_24);
    check("t1_ovf4",  int'(overflow4), 1);
    check("t1_over4", int'(out_over4), EXP4_OVER24);
    step();
    check("t1_idle_valid", int'(out_valid), 0);
    check("t1_idle_over",  int'(out_over), 0);
    check("t1_idle_state", int'(dut.state_q), int'(IDLE));

    // Gapped samples, ready held low for 5 cycles.
    out_ready = 1'b0;
    feed(2'd3);  // ignored in IDLE
    check("t2_idle_ignore", int'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      feed(2'(SUM_IDX[i]));
      if (i != 7) begin
        step();
        step();
      end
    end
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", int'(out_valid), 1);
      check("t2_hold_sum",   int'(out_sum), 6);
      check("t2_hold_over",  int'(out_over), 0);
      start = (i == 2); in_valid = 1'b1; in_data = 2'd3;
      step();
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("t2_still_valid", int'(out_valid), 1);
    step();
    check("t2_idle_state", int'(dut.state_q), int'(IDLE));
    check("t2_idle_valid", int'(out_valid), 0);

    // Restart mid-window after 4 samples of 2.
    out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) feed(2'd2);
    check("t4_partial", int'(out_sum), 8);
    start = 1'b1; in_valid = 1'b1; in_data = 2'd3;
    step();
    start = 1'b0; in_valid = 1'b0;
    check("t4_clr_sum",   int'(out_sum), 0);
    check("t4_clr_count", int'(dut.u_counter.count_q), 0);
    check("t4_clr_busy",  int'(busy), 1);
    for (int i = 0; i < 8; i++) feed(2'd1);
    check("t4_valid", int'(out_valid), 1);
    check("t4_sum",   int'(out_sum), 8);
    check("t4_over",  int'(out_over), 0);

    // Handshake and start together.
    out_ready = 1'b1; start = 1'b1;
    step();
    out_ready = 1'b0; start = 1'b0;
    check("t5_state", int'(dut.state_q), int'(ACC));
    check("t5_busy",  int'(busy), 1);
    check("t5_valid", int'(out_valid), 0);
    check("t5_sum",   int'(out_sum), 0);

    // Async reset mid-window.
    for (int i = 0; i < 3; i++) feed(2'd1);
    check("t6_partial", int'(out_sum), 3);
    #2 Rst_n = 1'b0;
    #1;
    check_cleared("t6_mid");
    #2 Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) feed(2'd3);
    check("t6_ignore_sum",   int'(out_sum), 0);
    check("t6_ignore_state", int'(dut.state_q), int'(IDLE));

    // Async reset while holding a result.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) feed(2'd2);
    check("t6_done_valid", int'(out_valid), 1);
    check("t6_done_sum",   int'(out_sum), 16);
    check("t6_done_over",  int'(out_over), 1);
    check("t6_done_sum4",  int'(out_sum4), EXP4_16);
    check("t6_done_ovf4",  int'(overflow4), 1);
    #2 Rst_n = 1'b0;
    #1;
    check_cleared("t6_done");
    check("t6_done_ovf4_rst", int'(overflow4), 0);
    #2 Rst_n = 1'b1;
    feed(2'd3);
    check("t6_after_state", int'(dut.state_q), int'(IDLE));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
